// File: rtl/clock_pkg.sv
// Shared widths, terminal values and state encoding for the clock datapath
// (time keeper, display and alarm blocks).
package clock_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);
   localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);

   typedef enum logic {
      RUN = 1'b0,
      SET = 1'b1
   } state_e;

endpackage : clock_pkg

// File: rtl/time_keeper_if.sv
// Control inputs and time outputs of the time keeper, grouped as one bundle.
interface time_keeper_if;

   logic                          clk_1;
   logic                          set_mode;
   logic                          inc_hour;
   logic                          inc_min;
   logic [clock_pkg::HOUR_W-1:0]  hour;
   logic [clock_pkg::MIN_W-1:0]   minute;
   logic [clock_pkg::SEC_W-1:0]   second;
   logic                          sec_tick;
   logic                          day_wrap;
   logic                          in_set;

   modport master (
      output clk_1, set_mode, inc_hour, inc_min,
      input  hour, minute, second, sec_tick, day_wrap, in_set
   );

   modport slave (
      input  clk_1, set_mode, inc_hour, inc_min,
      output hour, minute, second, sec_tick, day_wrap, in_set
   );

endinterface : time_keeper_if

// File: rtl/tick_edge_detect.sv
// Turns the slow divider toggle clk_1 into a combinational one-cycle edge flag.
module tick_edge_detect #(
   parameter bit TICK_BOTH_EDGES = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic clk_1,
   output logic sec_edge
);

   logic clk_1_d_q;
   logic clk_1_d_d;

   always_comb clk_1_d_d = clk_1;

   // Reset loads the live level so leaving reset never looks like an edge.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) clk_1_d_q <= clk_1;
      else     clk_1_d_q <= clk_1_d_d;
   end

   always_comb begin
      if (TICK_BOTH_EDGES) sec_edge = clk_1 ^ clk_1_d_q;
      else                 sec_edge = clk_1 & ~clk_1_d_q;
   end

endmodule : tick_edge_detect

// File: rtl/time_keeper.sv
// Binary hh:mm:ss time keeper with a RUN/SET state machine; advances one second
// per detected clk_1 edge and lets button pulses adjust hours/minutes in SET.
module time_keeper
   import clock_pkg::*;
#(
   parameter bit TICK_BOTH_EDGES = 1'b0,
   parameter int HOUR_MODULUS    = 24
) (
   input  logic          clk,
   input  logic          rst,
   time_keeper_if.slave  tk
);

   localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MODULUS - 1);

   state_e             state_q, state_d;
   logic [HOUR_W-1:0]  hour_q, hour_d;
   logic [MIN_W-1:0]   minute_q, minute_d;
   logic [SEC_W-1:0]   second_q, second_d;
   logic               sec_tick_q, sec_tick_d;
   logic               day_wrap_q, day_wrap_d;
   logic               sec_edge;

   tick_edge_detect #(
      .TICK_BOTH_EDGES (TICK_BOTH_EDGES)
   ) u_edge (
      .clk      (clk),
      .rst      (rst),
      .clk_1    (tk.clk_1),
      .sec_edge (sec_edge)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: if (tk.set_mode)  state_d = SET;
         SET: if (!tk.set_mode) state_d = RUN;
      endcase
   end

   always_comb begin
      hour_d     = hour_q;
      minute_d   = minute_q;
      second_d   = second_q;
      sec_tick_d = 1'b0;
      day_wrap_d = 1'b0;

      if (state_q == SET) begin
         if (tk.inc_min)  minute_d = (minute_q == MIN_MAX) ? '0 : minute_q + 1'b1;
         if (tk.inc_hour) hour_d   = (hour_q == HOUR_MAX)  ? '0 : hour_q + 1'b1;
      end else if (tk.set_mode) begin
         // Entering SET clears seconds and swallows a coincident edge.
         second_d = '0;
      end else if (sec_edge) begin
         sec_tick_d = 1'b1;
         if (second_q != SEC_MAX) begin
            second_d = second_q + 1'b1;
         end else begin
            second_d = '0;
            if (minute_q != MIN_MAX) begin
               minute_d = minute_q + 1'b1;
            end else begin
               minute_d = '0;
               if (hour_q != HOUR_MAX) begin
                  hour_d = hour_q + 1'b1;
               end else begin
                  hour_d     = '0;
                  day_wrap_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hour_q     <= '0;
         minute_q   <= '0;
         second_q   <= '0;
         sec_tick_q <= 1'b0;
         day_wrap_q <= 1'b0;
      end else begin
         hour_q     <= hour_d;
         minute_q   <= minute_d;
         second_q   <= second_d;
         sec_tick_q <= sec_tick_d;
         day_wrap_q <= day_wrap_d;
      end
   end

   always_comb begin
      tk.in_set   = (state_q == SET);
      tk.hour     = hour_q;
      tk.minute   = minute_q;
      tk.second   = second_q;
      tk.sec_tick = sec_tick_q;
      tk.day_wrap = day_wrap_q;
   end

endmodule : time_keeper
